// File: rtl/ascon_state_serializer_pkg.sv
// Types and helpers for the ASCON state read-out serializer.
// Holds the state type, read-out modes, FSM states and word-count helpers.
package ascon_state_serializer_pkg;

    // x0 occupies [319:256], x4 occupies [63:0]
    typedef logic [319:0] type_state;

    typedef enum logic [1:0] {
        SER_FULL   = 2'b00,
        SER_TAG    = 2'b01,
        SER_CIPHER = 2'b10,
        SER_RSVD   = 2'b11
    } ser_mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_t;

    localparam logic [3:0] SER_NW_FULL_32   = 4'd10;
    localparam logic [3:0] SER_NW_TAG_32    = 4'd4;
    localparam logic [3:0] SER_NW_CIPHER_32 = 4'd2;
    localparam logic [3:0] SER_NW_FULL_64   = 4'd5;
    localparam logic [3:0] SER_NW_TAG_64    = 4'd2;
    localparam logic [3:0] SER_NW_CIPHER_64 = 4'd1;

    function automatic logic [3:0] ser_nwords(
        input ser_mode_t mode,
        input int        word_w
    );
        logic [3:0] n;
        n = 4'd0;
        case (mode)
            SER_FULL:   n = (word_w == 32) ? SER_NW_FULL_32
                                           : SER_NW_FULL_64;
            SER_TAG:    n = (word_w == 32) ? SER_NW_TAG_32
                                           : SER_NW_TAG_64;
            SER_CIPHER: n = (word_w == 32) ? SER_NW_CIPHER_32
                                           : SER_NW_CIPHER_64;
            default:    n = 4'd0;
        endcase
        return n;
    endfunction

    // First word index of the burst; the tag starts at lane x3
    function automatic logic [3:0] ser_base(
        input ser_mode_t mode,
        input int        word_w
    );
        logic [3:0] b;
        b = 4'd0;
        if (mode == SER_TAG) begin
            b = (word_w == 32) ? 4'd6 : 4'd3;
        end
        return b;
    endfunction

endpackage

// File: rtl/ascon_state_serializer_if.sv
// Handshake bundle between the ASCON core, the serializer and the host side.
// master: drives load/mode/state and downstream ready; slave: the serializer.
interface ascon_state_serializer_if #(
    parameter int WORD_W = 32
);
    import ascon_state_serializer_pkg::*;

    logic              load_i;
    logic [1:0]        mode_i;
    type_state         state_i;
    logic              ready_o;
    logic [WORD_W-1:0] data_o;
    logic              valid_o;
    logic              ready_i;
    logic              last_o;
    logic              err_o;

    modport master (
        output load_i, mode_i, state_i, ready_i,
        input  ready_o, data_o, valid_o, last_o, err_o
    );

    modport slave (
        input  load_i, mode_i, state_i, ready_i,
        output ready_o, data_o, valid_o, last_o, err_o
    );

endinterface

// File: rtl/ascon_state_serializer.sv
// Snapshots the 320-bit ASCON state and streams FULL/TAG/CIPHER words out.
// Ports: clock_i, reset_i (sync, active high), bus (slave handshake bundle).
module ascon_state_serializer
    import ascon_state_serializer_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    ascon_state_serializer_if.slave bus
);

    localparam int NW = 320 / WORD_W;

    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
        $error("ascon_state_serializer: WORD_W must be 32 or 64");
    end

    ser_state_t state_q, state_d;
    type_state  snap_q, snap_d;
    ser_mode_t  mode_q, mode_d;
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    logic [3:0]        nw;
    logic [3:0]        idx;
    logic              last;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] words [NW];

    // Word 0 is the high half of x0 (big-endian order)
    for (genvar k = 0; k < NW; k++) begin : g_words
        assign words[k] = snap_q[319 - k*WORD_W -: WORD_W];
    end

    assign nw   = ser_nwords(mode_q, WORD_W);
    assign idx  = ser_base(mode_q, WORD_W) + cnt_q;
    assign last = (state_q == ST_SEND) && (cnt_q == nw - 4'd1);

    always_comb begin
        word = '0;
        for (int k = 0; k < NW; k++) begin
            if (idx == 4'(k)) word = words[k];
        end
    end

    assign bus.ready_o = (state_q == ST_IDLE);
    assign bus.valid_o = (state_q == ST_SEND);
    assign bus.last_o  = last;
    assign bus.data_o  = word;
    assign bus.err_o   = err_q;

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.load_i) begin
                    if (ser_mode_t'(bus.mode_i) == SER_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        snap_d  = bus.state_i;
                        mode_d  = ser_mode_t'(bus.mode_i);
                        cnt_d   = 4'd0;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (bus.ready_i) begin
                    if (last) begin
                        cnt_d   = 4'd0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            mode_q  <= SER_FULL;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_ascon_state_serializer.sv
// Scoreboard bench for ascon_state_serializer, WORD_W=32 and WORD_W=64.
// Expected words are queued at load time and popped by negedge monitors.
module tb_ascon_state_serializer;
    import ascon_state_serializer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ascon_state_serializer_if #(.WORD_W(32)) b32 ();
    ascon_state_serializer_if #(.WORD_W(64)) b64 ();

    ascon_state_serializer #(.WORD_W(32)) dut32 (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (b32)
    );

    ascon_state_serializer #(.WORD_W(64)) dut64 (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (b64)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [64:0] q32 [$];
    logic [64:0] q64 [$];

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic type_state mk_state(input logic [63:0] a,
                                           input logic [63:0] b,
                                           input logic [63:0] c,
                                           input logic [63:0] d,
                                           input logic [63:0] e);
        return {a, b, c, d, e};
    endfunction

    function automatic type_state rnd_state();
        type_state r;
        for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Push lanes first..first+n-1 of s; last flag on the final word
    task automatic expect_lanes(input int sel, input type_state s,
                                input int first, input int n);
        logic [63:0] x;
        for (int l = first; l < first + n; l++) begin
            x = s[319 - 64*l -: 64];
            if (sel == 32) begin
                q32.push_back({1'b0, 32'h0, x[63:32]});
                q32.push_back({(l == first + n - 1), 32'h0, x[31:0]});
            end else begin
                q64.push_back({(l == first + n - 1), x});
            end
        end
    endtask

    // Monitors sample at negedge: valid&&ready here means a transfer
    // at the coming rising edge.
    logic        st32 = 1'b0;
    logic [31:0] hd32;
    logic        hl32;
    always @(negedge clk) begin
        logic [64:0] e;
        if (rst) begin
            st32 = 1'b0;
        end else begin
            if (st32) begin
                check("stall_valid32", 64'(b32.valid_o), 64'd1);
                check("stall_data32", 64'(b32.data_o), 64'(hd32));
                check("stall_last32", 64'(b32.last_o), 64'(hl32));
            end
            st32 = 1'b0;
            if (b32.valid_o && b32.ready_i) begin
                if (q32.size() == 0) begin
                    check("unexpected32", 64'd1, 64'd0);
                end else begin
                    e = q32.pop_front();
                    check("data32", 64'(b32.data_o), 64'(e[31:0]));
                    check("last32", 64'(b32.last_o), 64'(e[64]));
                end
            end else if (b32.valid_o) begin
                st32 = 1'b1;
                hd32 = b32.data_o;
                hl32 = b32.last_o;
            end
        end
    end

    always @(negedge clk) begin
        logic [64:0] e;
        if (!rst && b64.valid_o && b64.ready_i) begin
            if (q64.size() == 0) begin
                check("unexpected64", 64'd1, 64'd0);
            end else begin
                e = q64.pop_front();
                check("data64", b64.data_o, e[63:0]);
                check("last64", 64'(b64.last_o), 64'(e[64]));
            end
        end
    end

    task automatic do_load(input int sel, input logic [1:0] mode,
                           input type_state s);
        if (sel == 32) begin
            b32.mode_i = mode; b32.state_i = s; b32.load_i = 1'b1;
        end else begin
            b64.mode_i = mode; b64.state_i = s; b64.load_i = 1'b1;
        end
        @(posedge clk); #1;
        if (sel == 32) begin
            b32.load_i = 1'b0; b32.state_i = rnd_state();
            check("lat_valid32", 64'(b32.valid_o), 64'd1);
            check("busy_ready32", 64'(b32.ready_o), 64'd0);
        end else begin
            b64.load_i = 1'b0; b64.state_i = rnd_state();
            check("lat_valid64", 64'(b64.valid_o), 64'd1);
            check("busy_ready64", 64'(b64.ready_o), 64'd0);
        end
    endtask

    task automatic drain(input int sel, input int bound, input bit rnd);
        int n = 0;
        while (((sel == 32) ? q32.size() : q64.size()) != 0 && n < bound) begin
            @(posedge clk); #1;
            n++;
            if (sel == 32 && rnd) begin
                b32.ready_i = 1'($urandom_range(0, 1));
            end
            if (sel == 32) b32.state_i = rnd_state();
            else           b64.state_i = rnd_state();
        end
        if (((sel == 32) ? q32.size() : q64.size()) != 0) begin
            check("timeout", 64'd1, 64'd0);
            q32.delete();
            q64.delete();
        end
        b32.ready_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [63:0] x0;
    type_state   sfull, stag, sa5, sb;

    initial begin
        b32.load_i = 1'b0; b32.mode_i = 2'b00; b32.state_i = '0;
        b32.ready_i = 1'b1;
        b64.load_i = 1'b0; b64.mode_i = 2'b00; b64.state_i = '0;
        b64.ready_i = 1'b1;
        x0 = 64'h0011223344556677;
        sfull = mk_state(x0, x0 + 64'd1, x0 + 64'd2, x0 + 64'd3, x0 + 64'd4);
        stag  = mk_state(rnd_state()[63:0], 64'h1, 64'h2,
                         64'hDEADBEEFCAFEF00D, 64'h0123456789ABCDEF);
        sa5   = mk_state(64'hA5A5A5A55A5A5A5A, 64'h11, 64'h22, 64'h33, 64'h44);
        sb    = rnd_state();

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid32", 64'(b32.valid_o), 64'd0);
        check("rst_ready32", 64'(b32.ready_o), 64'd1);
        check("rst_err32", 64'(b32.err_o), 64'd0);
        check("rst_last32", 64'(b32.last_o), 64'd0);
        check("rst_data32", 64'(b32.data_o), 64'd0);
        check("rst_valid64", 64'(b64.valid_o), 64'd0);
        check("rst_ready64", 64'(b64.ready_o), 64'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // FULL, 32-bit words, always ready
        expect_lanes(32, sfull, 0, 5);
        do_load(32, 2'b00, sfull);
        drain(32, 40, 1'b0);
        check("full_ready_after", 64'(b32.ready_o), 64'd1);
        check("full_valid_after", 64'(b32.valid_o), 64'd0);

        // TAG with random downstream stalls
        expect_lanes(32, stag, 3, 2);
        do_load(32, 2'b01, stag);
        drain(32, 200, 1'b1);
        check("tag_ready_after", 64'(b32.ready_o), 64'd1);

        // CIPHER with load held high: second load only after the burst
        expect_lanes(32, sa5, 0, 1);
        expect_lanes(32, sb, 0, 1);
        b32.mode_i = 2'b10; b32.state_i = sa5; b32.load_i = 1'b1;
        @(posedge clk); #1;
        b32.state_i = sb;
        check("cip_busy", 64'(b32.ready_o), 64'd0);
        @(posedge clk);
        @(posedge clk); #1;
        check("cip_ready_rise", 64'(b32.ready_o), 64'd1);
        @(posedge clk); #1;
        b32.load_i = 1'b0;
        b32.state_i = rnd_state();
        check("cip_reload", 64'(b32.ready_o), 64'd0);
        drain(32, 40, 1'b0);
        check("cip_idle", 64'(b32.ready_o), 64'd1);

        // Reserved mode
        b32.mode_i = 2'b11; b32.load_i = 1'b1;
        @(posedge clk); #1;
        b32.load_i = 1'b0;
        check("rsv_err", 64'(b32.err_o), 64'd1);
        check("rsv_valid", 64'(b32.valid_o), 64'd0);
        check("rsv_ready", 64'(b32.ready_o), 64'd1);
        @(posedge clk); #1;
        check("rsv_err_pulse", 64'(b32.err_o), 64'd0);
        check("rsv_valid2", 64'(b32.valid_o), 64'd0);

        // Reset in the middle of a FULL burst
        expect_lanes(32, sfull, 0, 5);
        do_load(32, 2'b00, sfull);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        b32.ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mrst_valid", 64'(b32.valid_o), 64'd0);
        check("mrst_ready", 64'(b32.ready_o), 64'd1);
        check("mrst_err", 64'(b32.err_o), 64'd0);
        check("mrst_data", 64'(b32.data_o), 64'd0);
        rst = 1'b0;
        q32.delete();
        b32.ready_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mrst_no_words", 64'(b32.valid_o), 64'd0);

        // FULL, 64-bit words
        expect_lanes(64, sfull, 0, 5);
        do_load(64, 2'b00, sfull);
        drain(64, 40, 1'b0);
        check("full64_ready_after", 64'(b64.ready_o), 64'd1);
        check("full64_valid_after", 64'(b64.valid_o), 64'd0);

        // CIPHER, 64-bit words: single word, last on it
        expect_lanes(64, sa5, 0, 1);
        do_load(64, 2'b10, sa5);
        drain(64, 20, 1'b0);
        check("cip64_ready_after", 64'(b64.ready_o), 64'd1);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
